mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_arb_pkg.sv | 15 +
 rtl/mem_port_arbiter.sv | 162 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the memory-port arbiter: FSM state encoding and requester IDs.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StBusyI = 2'd1,
    StBusyD = 2'd2
  } arb_state_t;

  typedef enum logic {
    ReqIf = 1'b0,
    ReqDm = 1'b1
  } req_id_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data-unit requests onto one shared cache port; all outputs registered.
// Define ARB_ROUND_ROBIN_EN for round-robin on simultaneous requests (default: data unit wins).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_done,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  input  logic [DATA_W/8-1:0] dm_be,
  output logic                dm_done,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  output logic                mem_re,
  output logic                mem_we,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_data_valid,
  input  logic                mem_write_complete
);

  localparam int unsigned BeW = DATA_W / 8;

  arb_state_t        r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nxt;
  logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata_nxt;
  logic [BeW-1:0]    r_mem_be, w_mem_be_nxt;
  logic              r_mem_re, w_mem_re_nxt;
  logic              r_mem_we, w_mem_we_nxt;
  logic              r_if_done, w_if_done_nxt;
  logic              r_dm_done, w_dm_done_nxt;
  logic [DATA_W-1:0] r_if_rdata, w_if_rdata_nxt;
  logic [DATA_W-1:0] r_dm_rdata, w_dm_rdata_nxt;
  req_id_t           w_winner;

`ifdef ARB_ROUND_ROBIN_EN
  req_id_t r_last_grant;

  // On a tie, hand the port to whoever did not win last time.
  always_comb begin
    if (dm_req && if_req) begin
      w_winner = (r_last_grant == ReqDm) ? ReqIf : ReqDm;
    end else begin
      w_winner = dm_req ? ReqDm : ReqIf;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_grant <= ReqIf;
    end else if (r_state == StIdle && (if_req || dm_req)) begin
      r_last_grant <= w_winner;
    end
  end
`else
  always_comb begin
    w_winner = dm_req ? ReqDm : ReqIf;
  end
`endif

  always_comb begin
    w_state_nxt     = r_state;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_mem_be_nxt    = r_mem_be;
    w_mem_re_nxt    = r_mem_re;
    w_mem_we_nxt    = r_mem_we;
    w_if_done_nxt   = 1'b0;
    w_dm_done_nxt   = 1'b0;
    w_if_rdata_nxt  = r_if_rdata;
    w_dm_rdata_nxt  = r_dm_rdata;
    unique case (r_state)
      StIdle: begin
        if (if_req || dm_req) begin
          if (w_winner == ReqDm) begin
            w_mem_addr_nxt  = dm_addr;
            w_mem_wdata_nxt = dm_wdata;
            w_mem_be_nxt    = dm_be;
            w_mem_re_nxt    = ~dm_we;
            w_mem_we_nxt    = dm_we;
            w_state_nxt     = StBusyD;
          end else begin
            w_mem_addr_nxt  = if_addr;
            w_mem_wdata_nxt = '0;
            w_mem_be_nxt    = '0;
            w_mem_re_nxt    = 1'b1;
            w_mem_we_nxt    = 1'b0;
            w_state_nxt     = StBusyI;
          end
        end
      end
      StBusyI: begin
        if (mem_data_valid) begin
          w_if_rdata_nxt = mem_rdata;
          w_if_done_nxt  = 1'b1;
          w_mem_re_nxt   = 1'b0;
          w_state_nxt    = StIdle;
        end
      end
      StBusyD: begin
        // The registered write enable records which strobe closes this transaction.
        if (r_mem_we ? mem_write_complete : mem_data_valid) begin
          if (!r_mem_we) begin
            w_dm_rdata_nxt = mem_rdata;
          end
          w_dm_done_nxt = 1'b1;
          w_mem_re_nxt  = 1'b0;
          w_mem_we_nxt  = 1'b0;
          w_state_nxt   = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= StIdle;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_be    <= '0;
      r_mem_re    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_if_done   <= 1'b0;
      r_dm_done   <= 1'b0;
      r_if_rdata  <= '0;
      r_dm_rdata  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_mem_be    <= w_mem_be_nxt;
      r_mem_re    <= w_mem_re_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_if_done   <= w_if_done_nxt;
      r_dm_done   <= w_dm_done_nxt;
      r_if_rdata  <= w_if_rdata_nxt;
      r_dm_rdata  <= w_dm_rdata_nxt;
    end
  end

  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_be    = r_mem_be;
  assign mem_re    = r_mem_re;
  assign mem_we    = r_mem_we;
  assign if_done   = r_if_done;
  assign dm_done   = r_dm_done;
  assign if_rdata  = r_if_rdata;
  assign dm_rdata  = r_dm_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: transaction-level model compared every cycle,
// plus directed scenarios with literal expectations. Honours ARB_ROUND_ROBIN_EN.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, dm_req, dm_we;
  logic [63:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic [7:0]  dm_be;
  logic        mem_data_valid, mem_write_complete;
  logic        if_done, dm_done, mem_re, mem_we;
  logic [63:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic [7:0]  mem_be;

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 1'b0;

  mem_port_arbiter dut (
    .clk                (clk),
    .reset              (reset),
    .if_req             (if_req),
    .if_addr            (if_addr),
    .if_done            (if_done),
    .if_rdata           (if_rdata),
    .dm_req             (dm_req),
    .dm_we              (dm_we),
    .dm_addr            (dm_addr),
    .dm_wdata           (dm_wdata),
    .dm_be              (dm_be),
    .dm_done            (dm_done),
    .dm_rdata           (dm_rdata),
    .mem_addr           (mem_addr),
    .mem_wdata          (mem_wdata),
    .mem_be             (mem_be),
    .mem_re             (mem_re),
    .mem_we             (mem_we),
    .mem_rdata          (mem_rdata),
    .mem_data_valid     (mem_data_valid),
    .mem_write_complete (mem_write_complete)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Transaction-level model: one outstanding transaction, owner and direction remembered.
  bit          m_busy, m_owner_d, m_wr, m_last_d;
  logic        e_if_done, e_dm_done, e_re, e_we;
  logic [63:0] e_if_rdata, e_dm_rdata, e_addr, e_wdata;
  logic [7:0]  e_be;

  always @(posedge clk) begin
    bit pick_d;
    if (reset) begin
      m_busy = 0; m_owner_d = 0; m_wr = 0; m_last_d = 0;
      e_if_done = 0; e_dm_done = 0; e_re = 0; e_we = 0;
      e_if_rdata = 0; e_dm_rdata = 0; e_addr = 0; e_wdata = 0; e_be = 0;
    end else begin
      e_if_done = 0;
      e_dm_done = 0;
      if (!m_busy) begin
        if (if_req || dm_req) begin
`ifdef ARB_ROUND_ROBIN_EN
          pick_d = dm_req && (!if_req || !m_last_d);
`else
          pick_d = dm_req;
`endif
          m_busy = 1; m_owner_d = pick_d; m_last_d = pick_d;
          if (pick_d) begin
            e_addr = dm_addr; e_wdata = dm_wdata; e_be = dm_be;
            m_wr = dm_we; e_re = !dm_we; e_we = dm_we;
          end else begin
            e_addr = if_addr; e_wdata = 0; e_be = 0;
            m_wr = 0; e_re = 1; e_we = 0;
          end
        end
      end else if (!m_owner_d && mem_data_valid) begin
        e_if_rdata = mem_rdata; e_if_done = 1; e_re = 0; m_busy = 0;
      end else if (m_owner_d && (m_wr ? mem_write_complete : mem_data_valid)) begin
        if (!m_wr) e_dm_rdata = mem_rdata;
        e_dm_done = 1; e_re = 0; e_we = 0; m_busy = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cmp_if_done", if_done, e_if_done);
      check("cmp_dm_done", dm_done, e_dm_done);
      check("cmp_if_rdata", if_rdata, e_if_rdata);
      check("cmp_dm_rdata", dm_rdata, e_dm_rdata);
      check("cmp_mem_addr", mem_addr, e_addr);
      check("cmp_mem_wdata", mem_wdata, e_wdata);
      check("cmp_mem_be", {56'd0, mem_be}, {56'd0, e_be});
      check("cmp_mem_re", mem_re, e_re);
      check("cmp_mem_we", mem_we, e_we);
      check("cmp_done_excl", if_done && dm_done, 1'b0);
      check("cmp_en_excl", mem_re && mem_we, 1'b0);
    end
  end

  // Plays the cache: waits for an enable, answers after lat enabled cycles.
  // Returns at the negedge of the done cycle.
  task automatic serve(input int lat, input logic [63:0] rd, output int en_cycles,
                       output bit first_we, output bit ok);
    ok = 0; en_cycles = 0; first_we = 0;
    for (int i = 0; i < 20 && !(mem_re || mem_we); i++) @(negedge clk);
    if (!(mem_re || mem_we)) begin
      $display("FAIL serve_timeout: got no enable expected mem_re or mem_we");
      n_checks++;
      return;
    end
    first_we = mem_we;
    for (int i = 1; i < lat; i++) begin
      en_cycles += (mem_re || mem_we) ? 1 : 0;
      @(negedge clk);
    end
    en_cycles += (mem_re || mem_we) ? 1 : 0;
    mem_rdata          = rd;
    mem_data_valid     = !mem_we;
    mem_write_complete = mem_we;
    @(negedge clk);
    mem_data_valid     = 0;
    mem_write_complete = 0;
    ok = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    bit fw, ok;
    reset = 1; if_req = 0; dm_req = 0; dm_we = 0;
    if_addr = 0; dm_addr = 0; dm_wdata = 0; dm_be = 0; mem_rdata = 0;
    mem_data_valid = 0; mem_write_complete = 0;
    repeat (3) @(negedge clk);
    cmp_en = 1;
    check("rst_mem_re", mem_re, 0);
    check("rst_if_done", if_done, 0);
    check("rst_mem_addr", mem_addr, 0);
    reset = 0;
    @(negedge clk);

    // Fetch with 3-cycle latency.
    if_addr = 64'h1000; if_req = 1;
    serve(3, 64'hDEAD, cnt, fw, ok);
    check("s1_ok", ok, 1);
    check("s1_re_cycles", cnt, 3);
    check("s1_if_done", if_done, 1);
    check("s1_if_rdata", if_rdata, 64'hDEAD);
    if_req = 0;
    @(negedge clk);

    // Spurious strobes while idle.
    mem_rdata = 64'hFFFF; mem_data_valid = 1; mem_write_complete = 1;
    @(negedge clk);
    mem_data_valid = 0; mem_write_complete = 0;
    @(negedge clk);
    check("s5_if_done", if_done, 0);
    check("s5_dm_done", dm_done, 0);
    check("s5_if_rdata", if_rdata, 64'hDEAD);

    // Simultaneous write + fetch, twice: D, I, D, I in both builds.
    for (int r = 0; r < 2; r++) begin
      dm_we = 1; dm_addr = 64'h2000; dm_wdata = 64'h55AA + r; dm_be = 8'hFF;
      if_addr = 64'h3000 + r; dm_req = 1; if_req = 1;
      serve(2, 64'h0, cnt, fw, ok);
      check("s2_first_is_d", fw, 1);
      check("s2_dm_done", dm_done, 1);
      check("s2_gap_idle", mem_re || mem_we, 0);
      dm_req = 0;
      serve(2, 64'hBEEF + r, cnt, fw, ok);
      check("s2_second_is_i", fw, 0);
      check("s2_if_done", if_done, 1);
      check("s2_if_rdata", if_rdata, 64'hBEEF + r);
      if_req = 0;
      @(negedge clk);
    end

    // After a lone data write, a tie goes to fetch only under round-robin.
    dm_we = 1; dm_addr = 64'h2100; dm_req = 1;
    serve(1, 64'h0, cnt, fw, ok);
    dm_req = 0;
    @(negedge clk);
    dm_req = 1; if_req = 1; if_addr = 64'h3100;
    serve(1, 64'h77, cnt, fw, ok);
`ifdef ARB_ROUND_ROBIN_EN
    check("s3_tie_winner_we", fw, 0);
    if_req = 0;
`else
    check("s3_tie_winner_we", fw, 1);
    dm_req = 0;
`endif
    serve(1, 64'h88, cnt, fw, ok);
    check("s3_other_done", if_done || dm_done, 1);
    dm_req = 0; if_req = 0;
    @(negedge clk);

    // Data read with partial byte enables.
    dm_we = 0; dm_be = 8'h0F; dm_addr = 64'h4000; dm_req = 1;
    @(negedge clk);
    check("s6_mem_be", {56'd0, mem_be}, 64'h0F);
    check("s6_mem_re", mem_re, 1);
    serve(2, 64'h1234, cnt, fw, ok);
    check("s6_dm_done", dm_done, 1);
    check("s6_dm_rdata", dm_rdata, 64'h1234);
    dm_req = 0;
    @(negedge clk);

    // Reset in the middle of a write drops it silently.
    dm_we = 1; dm_addr = 64'h5000; dm_req = 1;
    @(negedge clk);
    @(negedge clk);
    check("s4_mem_we_busy", mem_we, 1);
    reset = 1; dm_req = 0;
    @(negedge clk);
    check("s4_mem_we_rst", mem_we, 0);
    check("s4_dm_done_rst", dm_done, 0);
    check("s4_dm_rdata_rst", dm_rdata, 0);
    reset = 0;
    repeat (3) begin
      @(negedge clk);
      check("s4_no_done", dm_done, 0);
    end
    dm_req = 1;
    serve(2, 64'h0, cnt, fw, ok);
    check("s4_rereq_done", dm_done, 1);
    dm_req = 0;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
